ttl_193_sequencer: RTL and testbench
====================================

Name: ttl_193_sequencer

Overview:
- Synchronous controller that drives the pins of an external 74193-style 4-bit up/down counter chain, such as the stack or index pointer in cpu5.
- Accepts INC / DEC / LOAD / CLEAR commands over a valid/ready handshake.
- Converts each command into properly timed CPU, CPD, PL_bar and MR strobes with programmable pulse and gap widths.
- Keeps a shadow copy of the counter value and flags wrap-around carry and borrow for each command.

Parameters:
- WIDTH, 4: counter, load-data and step-count width.
- PULSE_W, 2: cycles each strobe is held in its active level (≥1).
- GAP_W, 1: cycles each strobe is held inactive after a pulse, before the next pulse or completion (≥1).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_bar  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  controller idle and able to accept a command.
- CMD  in  2  00 INC, 01 DEC, 10 LOAD, 11 CLEAR.
- CMD_DATA  in  WIDTH  step count N for INC/DEC; load value for LOAD; ignored for CLEAR.
- DONE  out  1  one-cycle completion pulse.
- CPU  out  1  count-up clock to the counter; idles high.
- CPD  out  1  count-down clock to the counter; idles high.
- MR  out  1  master reset to the counter; active high.
- PL_bar  out  1  parallel load to the counter; active low.
- D  out  WIDTH  parallel load data to the counter.
- SHADOW_Q  out  WIDTH  expected counter value.
- CARRY  out  1  an increment wrapped from all-ones to 0 during the last command.
- BORROW  out  1  a decrement wrapped from 0 to all-ones during the last command.

Behaviour:
- All outputs are registered. Only one strobe pin is ever active at a time.
- Reset:
  - While RST_bar=0, outputs are forced asynchronously to: MR=1, CPU=1, CPD=1, PL_bar=1, D=0, SHADOW_Q=0, CARRY=0, BORROW=0, DONE=0, CMD_READY=0, state INIT.
  - Because CPU and CPD are forced high, an aborted low phase may produce a rising edge at the chip. MR=1 overrides that edge, so the chip and the shadow agree.
- States:
  - INIT: MR held 1 for PULSE_W cycles after RST_bar rises, then MR=0 and go to GAP. No DONE is issued for INIT.
  - IDLE: CMD_READY=1. A command is accepted at the edge where CMD_VALID & CMD_READY (edge E0). At E0, CMD and CMD_DATA are latched, CARRY and BORROW are cleared, and CMD_READY drops.
  - ACTIVE: the selected pin is held active for PULSE_W cycles.
    - INC: CPU=0. DEC: CPD=0.
    - LOAD: PL_bar=0; D is loaded from CMD_DATA at E0.
    - CLEAR: MR=1.
  - GAP: all strobes inactive for GAP_W cycles.
    - If more INC/DEC steps remain, return to ACTIVE.
    - Otherwise go to IDLE with DONE=1 and CMD_READY=1 in the same cycle.
- Shadow update happens at the edge where the strobe returns inactive (the chip's rising CPU/CPD edge, or PL_bar/MR release):
  - INC: SHADOW_Q+1 mod 2^WIDTH; CARRY set if the old value was all-ones.
  - DEC: SHADOW_Q-1 mod 2^WIDTH; BORROW set if the old value was 0.
  - LOAD: SHADOW_Q=D. CLEAR: SHADOW_Q=0.
- CARRY and BORROW are sticky until the next accepted command.
- Latency:
  - DONE and CMD_READY rise at E0 + N*(PULSE_W+GAP_W) for INC/DEC.
  - DONE and CMD_READY rise at E0 + PULSE_W+GAP_W for LOAD/CLEAR.
  - INC/DEC with N=0: no strobes; DONE and CMD_READY at E0+1; shadow and flags unchanged apart from the clear at E0.
- D is held stable from E0 through the end of GAP, and keeps its value until the next LOAD.
- CMD_VALID while CMD_READY=0 is ignored. The command is not queued; the requester must hold it until accepted.
- A new command may be accepted in the same cycle that DONE=1.

Test Plan (WIDTH=4, PULSE_W=2, GAP_W=1):
- Release RST_bar -> MR=1 for 2 cycles then 0; CMD_READY=1 at release+3; SHADOW_Q=0; no DONE.
- LOAD 0xE, then INC N=3 -> CPU low 2 cycles and high 1 cycle, three times; SHADOW_Q goes E,F,0,1; CARRY=1; DONE at E0+9.
- DEC N=2 from 0x1 -> CPD pulses twice; SHADOW_Q goes 0,F; BORROW=1, CARRY=0; CPU stays 1 throughout.
- INC N=0 -> no strobe toggles; DONE and CMD_READY at E0+1; SHADOW_Q unchanged.
- Pull RST_bar low mid-way through an INC low phase -> CPU=1 and MR=1 immediately; after release, INIT completes and SHADOW_Q=0.
- CMD_VALID held with a different CMD while busy -> no effect until CMD_READY=1, then accepted; back-to-back acceptance on the DONE cycle works.

Source files
------------

// File: rtl/ttl_193_sequencer.sv
// Pin sequencer for an external 74193-style up/down counter chain.
// Turns INC/DEC/LOAD/CLEAR commands into timed CPU/CPD/PL_bar/MR strobes and mirrors the count.
module ttl_193_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic             CLK,
  input  logic             RST_bar,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             DONE,
  output logic             CPU,
  output logic             CPD,
  output logic             MR,
  output logic             PL_bar,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] SHADOW_Q,
  output logic             CARRY,
  output logic             BORROW
);

  typedef enum logic [1:0] {CMD_INC = 2'b00, CMD_DEC = 2'b01, CMD_LOAD = 2'b10, CMD_CLEAR = 2'b11} cmd_e;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACTIVE, S_GAP, S_NOP} state_e;

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

  state_e           state, state_n;
  cmd_e             cmd_q, cmd_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] steps, steps_n;
  logic             booting, booting_n;
  logic             ready_n, done_n, cpu_n, cpd_n, mr_n, pl_n, carry_n, borrow_n;
  logic [WIDTH-1:0] d_n, shadow_n;

  // NOTE: every registered signal uses non-blocking assignment so all flops sample the same pre-edge values.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state     <= S_INIT;
      cmd_q     <= CMD_INC;
      cnt       <= '0;
      steps     <= '0;
      booting   <= 1'b1;
      CMD_READY <= 1'b0;
      DONE      <= 1'b0;
      CPU       <= 1'b1;
      CPD       <= 1'b1;
      MR        <= 1'b1;
      PL_bar    <= 1'b1;
      D         <= '0;
      SHADOW_Q  <= '0;
      CARRY     <= 1'b0;
      BORROW    <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_q     <= cmd_n;
      cnt       <= cnt_n;
      steps     <= steps_n;
      booting   <= booting_n;
      CMD_READY <= ready_n;
      DONE      <= done_n;
      CPU       <= cpu_n;
      CPD       <= cpd_n;
      MR        <= mr_n;
      PL_bar    <= pl_n;
      D         <= d_n;
      SHADOW_Q  <= shadow_n;
      CARRY     <= carry_n;
      BORROW    <= borrow_n;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cmd_n     = cmd_q;
    cnt_n     = cnt + 1'b1;
    steps_n   = steps;
    booting_n = booting;
    ready_n   = CMD_READY;
    done_n    = 1'b0;
    cpu_n     = CPU;
    cpd_n     = CPD;
    mr_n      = MR;
    pl_n      = PL_bar;
    d_n       = D;
    shadow_n  = SHADOW_Q;
    carry_n   = CARRY;
    borrow_n  = BORROW;

    unique case (state)
      S_INIT: begin
        if (cnt == PULSE_LAST) begin
          mr_n    = 1'b0;
          cnt_n   = '0;
          state_n = S_GAP;
        end
      end

      S_IDLE: begin
        cnt_n = '0;
        if (CMD_VALID && CMD_READY) begin
          cmd_n    = cmd_e'(CMD);
          ready_n  = 1'b0;
          carry_n  = 1'b0;
          borrow_n = 1'b0;
          steps_n  = 1'b1;
          state_n  = S_ACTIVE;
          unique case (cmd_e'(CMD))
            CMD_INC, CMD_DEC: begin
              steps_n = CMD_DATA;
              if (CMD_DATA == '0) state_n = S_NOP;
              else if (cmd_e'(CMD) == CMD_INC) cpu_n = 1'b0;
              else cpd_n = 1'b0;
            end
            CMD_LOAD: begin
              d_n  = CMD_DATA;
              pl_n = 1'b0;
            end
            CMD_CLEAR: mr_n = 1'b1;
          endcase
        end
      end

      S_ACTIVE: begin
        if (cnt == PULSE_LAST) begin
          // Releasing the strobe is the chip's active edge, so the shadow moves here.
          cpu_n   = 1'b1;
          cpd_n   = 1'b1;
          pl_n    = 1'b1;
          mr_n    = 1'b0;
          steps_n = steps - 1'b1;
          cnt_n   = '0;
          state_n = S_GAP;
          unique case (cmd_q)
            CMD_INC: begin
              shadow_n = SHADOW_Q + 1'b1;
              if (&SHADOW_Q) carry_n = 1'b1;
            end
            CMD_DEC: begin
              shadow_n = SHADOW_Q - 1'b1;
              if (SHADOW_Q == '0) borrow_n = 1'b1;
            end
            CMD_LOAD:  shadow_n = D;
            CMD_CLEAR: shadow_n = '0;
          endcase
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (booting) begin
            booting_n = 1'b0;
            ready_n   = 1'b1;
            state_n   = S_IDLE;
          end else if (steps != '0) begin
            state_n = S_ACTIVE;
            if (cmd_q == CMD_INC) cpu_n = 1'b0;
            else cpd_n = 1'b0;
          end else begin
            done_n  = 1'b1;
            ready_n = 1'b1;
            state_n = S_IDLE;
          end
        end
      end

      S_NOP: begin
        done_n  = 1'b1;
        ready_n = 1'b1;
        cnt_n   = '0;
        state_n = S_IDLE;
      end

      default: state_n = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_ttl_193_sequencer.sv
// Directed bench for ttl_193_sequencer (WIDTH=4, PULSE_W=2, GAP_W=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ttl_193_sequencer;

  logic       CLK = 1'b0;
  logic       RST_bar, CMD_VALID, CMD_READY, DONE, CPU, CPD, MR, PL_bar, CARRY, BORROW;
  logic [1:0] CMD;
  logic [3:0] CMD_DATA, D, SHADOW_Q;

  int total = 0;
  int bad   = 0;

  logic       inc_cpu[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] inc_sh[10]  = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
  logic       dec_cpd[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] dec_sh[7]   = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};

  ttl_193_sequencer #(.WIDTH(4), .PULSE_W(2), .GAP_W(1)) dut (
    .CLK(CLK), .RST_bar(RST_bar), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD(CMD), .CMD_DATA(CMD_DATA), .DONE(DONE), .CPU(CPU), .CPD(CPD), .MR(MR),
    .PL_bar(PL_bar), .D(D), .SHADOW_Q(SHADOW_Q), .CARRY(CARRY), .BORROW(BORROW)
  );

  always #5 CLK = ~CLK;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_nib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Presents a command for one edge; the caller samples right after the accepting edge.
  task automatic send(input logic [1:0] c, input logic [3:0] data);
    check_bit("ready_before_send", CMD_READY, 1'b1);
    CMD_VALID = 1'b1;
    CMD       = c;
    CMD_DATA  = data;
    tick();
    CMD_VALID = 1'b0;
  endtask

  initial begin
    RST_bar = 1'b0; CMD_VALID = 1'b0; CMD = 2'b00; CMD_DATA = 4'h0;
    repeat (2) tick();
    check_bit("rst_mr", MR, 1'b1);
    check_bit("rst_cpu", CPU, 1'b1);
    check_bit("rst_cpd", CPD, 1'b1);
    check_bit("rst_pl", PL_bar, 1'b1);
    check_bit("rst_ready", CMD_READY, 1'b0);
    check_nib("rst_shadow", SHADOW_Q, 4'h0);

    // Reset release and INIT sequence.
    RST_bar = 1'b1;
    tick(); check_bit("init1_mr", MR, 1'b1); check_bit("init1_ready", CMD_READY, 1'b0);
    tick(); check_bit("init2_mr", MR, 1'b0); check_bit("init2_ready", CMD_READY, 1'b0);
    tick(); check_bit("init3_ready", CMD_READY, 1'b1); check_bit("init3_done", DONE, 1'b0);
    check_nib("init3_shadow", SHADOW_Q, 4'h0);

    // LOAD 0xE.
    send(2'b10, 4'hE);
    check_bit("load0_pl", PL_bar, 1'b0); check_nib("load0_d", D, 4'hE);
    check_bit("load0_ready", CMD_READY, 1'b0);
    tick(); check_bit("load1_pl", PL_bar, 1'b0);
    tick(); check_bit("load2_pl", PL_bar, 1'b1); check_nib("load2_shadow", SHADOW_Q, 4'hE);
    tick(); check_bit("load3_done", DONE, 1'b1); check_bit("load3_ready", CMD_READY, 1'b1);

    // INC N=3 accepted on the DONE cycle; wraps F->0.
    send(2'b00, 4'd3);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check_bit($sformatf("inc3_cpu_%0d", k), CPU, inc_cpu[k]);
      check_bit($sformatf("inc3_cpd_%0d", k), CPD, 1'b1);
      check_nib($sformatf("inc3_shadow_%0d", k), SHADOW_Q, inc_sh[k]);
      check_bit($sformatf("inc3_done_%0d", k), DONE, k == 9);
      check_bit($sformatf("inc3_carry_%0d", k), CARRY, k >= 5);
    end
    check_bit("inc3_ready", CMD_READY, 1'b1);

    // DEC N=2 from 1; wraps 0->F.
    send(2'b01, 4'd2);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      check_bit($sformatf("dec2_cpd_%0d", k), CPD, dec_cpd[k]);
      check_bit($sformatf("dec2_cpu_%0d", k), CPU, 1'b1);
      check_nib($sformatf("dec2_shadow_%0d", k), SHADOW_Q, dec_sh[k]);
      check_bit($sformatf("dec2_done_%0d", k), DONE, k == 6);
      check_bit($sformatf("dec2_borrow_%0d", k), BORROW, k >= 5);
      check_bit($sformatf("dec2_carry_%0d", k), CARRY, 1'b0);
    end

    // INC N=0: no strobes, flags cleared, done after one cycle.
    send(2'b00, 4'd0);
    check_bit("inc0_cpu", CPU, 1'b1); check_bit("inc0_cpd", CPD, 1'b1);
    check_bit("inc0_ready", CMD_READY, 1'b0); check_bit("inc0_done", DONE, 1'b0);
    check_bit("inc0_borrow", BORROW, 1'b0);
    tick(); check_bit("inc0_done1", DONE, 1'b1); check_bit("inc0_ready1", CMD_READY, 1'b1);
    check_bit("inc0_cpu1", CPU, 1'b1); check_nib("inc0_shadow", SHADOW_Q, 4'hF);

    // DEC 1 with a CLEAR held on CMD_VALID while busy.
    tick();
    CMD_VALID = 1'b1; CMD = 2'b01; CMD_DATA = 4'd1;
    tick();
    CMD = 2'b11; CMD_DATA = 4'h9;
    check_bit("busy0_cpd", CPD, 1'b0); check_bit("busy0_mr", MR, 1'b0);
    tick(); check_bit("busy1_mr", MR, 1'b0); check_bit("busy1_cpd", CPD, 1'b0);
    tick(); check_bit("busy2_cpd", CPD, 1'b1); check_nib("busy2_shadow", SHADOW_Q, 4'hE);
    check_bit("busy2_mr", MR, 1'b0);
    tick(); check_bit("busy3_done", DONE, 1'b1); check_bit("busy3_mr", MR, 1'b0);
    tick(); CMD_VALID = 1'b0;
    check_bit("clr0_mr", MR, 1'b1); check_bit("clr0_done", DONE, 1'b0);
    check_bit("clr0_ready", CMD_READY, 1'b0);
    tick(); check_bit("clr1_mr", MR, 1'b1); check_nib("clr1_shadow", SHADOW_Q, 4'hE);
    tick(); check_bit("clr2_mr", MR, 1'b0); check_nib("clr2_shadow", SHADOW_Q, 4'h0);
    tick(); check_bit("clr3_done", DONE, 1'b1);

    // LOAD 7, then reset in the middle of an INC low phase.
    send(2'b10, 4'h7);
    repeat (3) tick();
    check_nib("load7_shadow", SHADOW_Q, 4'h7); check_bit("load7_done", DONE, 1'b1);
    send(2'b00, 4'd2);
    check_bit("abort_cpu_low", CPU, 1'b0);
    #2 RST_bar = 1'b0;
    #1;
    check_bit("abort_cpu", CPU, 1'b1); check_bit("abort_mr", MR, 1'b1);
    check_bit("abort_ready", CMD_READY, 1'b0); check_nib("abort_shadow", SHADOW_Q, 4'h0);
    tick(); RST_bar = 1'b1;
    tick(); check_bit("reinit1_mr", MR, 1'b1);
    tick(); check_bit("reinit2_mr", MR, 1'b0);
    tick(); check_bit("reinit3_ready", CMD_READY, 1'b1); check_bit("reinit3_done", DONE, 1'b0);
    check_nib("reinit3_shadow", SHADOW_Q, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
